// File: rtl/display_pkg.sv
// Shared code-field positions, segment patterns and scan FSM type for the display driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_pkg;

   localparam int NUM_DIGITS = 8;

   // Digit code fields: [3:0] glyph, [4] reserved, [5] decimal point, [6] blank.
   localparam int GLYPH_MSB = 3;
   localparam int DP_BIT    = 5;
   localparam int BLANK_BIT = 6;

   typedef logic [6:0] code_t;

   // Shadow reset value: blank bit set, everything else clear.
   localparam code_t CODE_BLANK = 7'h40;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_P = 7'h0C;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam logic [6:0] SEG_ALL_ON = 7'h00;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

endpackage

// File: rtl/sevenseg_scan_if.sv
// Bundle between the clock core (digit codes, lamp test) and the display pins.
// Latency: n/a (wiring only).
// Backpressure: none; digit codes are level signals sampled by the scanner.
// Ports: d0..d7 digit codes and lamp_test (master -> slave); segs_n, dp_n, an_n display drive (slave -> master).
interface sevenseg_scan_if;
   import display_pkg::*;

   code_t      d0, d1, d2, d3, d4, d5, d6, d7;
   logic       lamp_test;
   logic [6:0] segs_n;
   logic       dp_n;
   logic [7:0] an_n;

   modport master (
      output d0, d1, d2, d3, d4, d5, d6, d7, lamp_test,
      input  segs_n, dp_n, an_n
   );

   modport slave (
      input  d0, d1, d2, d3, d4, d5, d6, d7, lamp_test,
      output segs_n, dp_n, an_n
   );

endinterface

// File: rtl/seg7_decode.sv
// Combinational hex/letter glyph to active-low seven-segment pattern.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: glyph (4-bit code in), segs_n (7-bit {g,f,e,d,c,b,a} active-low out).
module seg7_decode
   import display_pkg::*;
(
   input  logic [GLYPH_MSB:0] glyph,
   output logic [6:0]         segs_n
);

   always_comb begin
      segs_n = SEG_BLANK;
      unique case (glyph)
         4'd0:  segs_n = SEG_0;
         4'd1:  segs_n = SEG_1;
         4'd2:  segs_n = SEG_2;
         4'd3:  segs_n = SEG_3;
         4'd4:  segs_n = SEG_4;
         4'd5:  segs_n = SEG_5;
         4'd6:  segs_n = SEG_6;
         4'd7:  segs_n = SEG_7;
         4'd8:  segs_n = SEG_8;
         4'd9:  segs_n = SEG_9;
         4'd10: segs_n = SEG_A;
         4'd11: segs_n = SEG_P;
         4'd12: segs_n = SEG_C;
         4'd13: segs_n = SEG_D;
         4'd14: segs_n = SEG_E;
         4'd15: segs_n = SEG_F;
         default: segs_n = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed 8-digit common-anode driver with frame-tear-free shadow bank and anti-ghost blanking.
// Latency: 1 cycle from scan state / lamp_test to the registered pin outputs.
// Backpressure: none; digit codes are sampled only at the frame boundary, lamp_test every cycle.
// Ports: clk, rst (async active-low); disp (slave): d0..d7, lamp_test in; segs_n, dp_n, an_n out.
module sevenseg_scan
   import display_pkg::*;
#(
   parameter int DIV       = 100000,
   parameter int BLANK_CYC = 4
) (
   input  logic           clk,
   input  logic           rst,
   sevenseg_scan_if.slave disp
);

   localparam int            CW         = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   scan_state_t   state_q, state_d;
   code_t         sh_q [NUM_DIGITS];
   code_t         sh_d [NUM_DIGITS];

   logic [7:0]    an_n_q, an_n_d;
   logic [6:0]    segs_n_q, segs_n_d;
   logic          dp_n_q, dp_n_d;

   logic          tick;
   logic          frame_end;
   code_t         cur_code;
   logic [6:0]    dec_segs_n;
   logic          unused_rsvd;

   assign tick      = (cnt_q == CNT_LAST);
   assign frame_end = tick && (idx_q == 3'd7);
   assign cur_code  = sh_q[idx_q];

   // Reserved code bit carries no meaning for the display.
   assign unused_rsvd = cur_code[4];

   // Prescaler and slot index.
   always_comb begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      idx_d = tick ? idx_q + 3'd1 : idx_q;
   end

   // Whole bank reloads together on the last tick of slot 7 so a frame never mixes old and new digits.
   always_comb begin
      sh_d = sh_q;
      if (frame_end) begin
         sh_d[0] = disp.d0;
         sh_d[1] = disp.d1;
         sh_d[2] = disp.d2;
         sh_d[3] = disp.d3;
         sh_d[4] = disp.d4;
         sh_d[5] = disp.d5;
         sh_d[6] = disp.d6;
         sh_d[7] = disp.d7;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         idx_q <= 3'd0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            sh_q[i] <= CODE_BLANK;
         end
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         sh_q  <= sh_d;
      end
   end

   // FSM: state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= BLANK;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state. Going to BLANK on the same edge that advances idx
   // keeps the old anode off before the new one can turn on.
   always_comb begin
      state_d = state_q;
      if (tick) begin
         state_d = BLANK;
      end else if ((state_q == BLANK) && (cnt_q == BLANK_LAST)) begin
         state_d = SHOW;
      end
   end

   seg7_decode u_decode (
      .glyph  (cur_code[GLYPH_MSB:0]),
      .segs_n (dec_segs_n)
   );

   // FSM: outputs, computed here and registered below.
   always_comb begin
      an_n_d   = 8'hFF;
      segs_n_d = SEG_BLANK;
      dp_n_d   = 1'b1;
      if (state_q == SHOW) begin
         an_n_d = ~(8'b1 << idx_q);
         if (disp.lamp_test) begin
            segs_n_d = SEG_ALL_ON;
            dp_n_d   = 1'b0;
         end else if (cur_code[BLANK_BIT]) begin
            // Blank digit suppresses its decimal point too.
            segs_n_d = SEG_BLANK;
            dp_n_d   = 1'b1;
         end else begin
            segs_n_d = dec_segs_n;
            dp_n_d   = ~cur_code[DP_BIT];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an_n_q   <= 8'hFF;
         segs_n_q <= SEG_BLANK;
         dp_n_q   <= 1'b1;
      end else begin
         an_n_q   <= an_n_d;
         segs_n_q <= segs_n_d;
         dp_n_q   <= dp_n_d;
      end
   end

   assign disp.an_n   = an_n_q;
   assign disp.segs_n = segs_n_q;
   assign disp.dp_n   = dp_n_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Testbench for sevenseg_scan: randomized and directed digit codes scored against a frame-level model.
// Latency: expects pin outputs one edge after each scan state.
// Backpressure: n/a.
module tb_sevenseg_scan;

   localparam int DIV       = 8;
   localparam int BLANK_CYC = 2;
   localparam int FRAME     = 8 * DIV;

   typedef struct packed {
      int         tag;
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
   } out_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sevenseg_scan_if dif ();

   sevenseg_scan #(
      .DIV       (DIV),
      .BLANK_CYC (BLANK_CYC)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .disp (dif)
   );

   // Reference glyph table, written straight from the display's character set.
   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h0C, 7'h46, 7'h21, 7'h06, 7'h0E};

   int         checks = 0;
   int         errors = 0;
   int         m      = 0;            // scan cycles elapsed since reset release
   logic [6:0] sh     [8];            // digits latched for the frame being shown
   logic [6:0] d_nxt  [8];
   logic       lamp_nxt = 1'b0;
   out_t       exp_q  [$];

   // Expected pins produced by scan cycle mm: slot = mm/DIV, first BLANK_CYC cycles dark.
   function automatic out_t model_out(int mm, logic lamp);
      out_t       o;
      int         pos;
      int         slot;
      logic [6:0] c;
      pos   = mm % DIV;
      slot  = (mm / DIV) % 8;
      c     = sh[slot];
      o.tag = mm;
      o.an  = 8'hFF;
      o.seg = 7'h7F;
      o.dp  = 1'b1;
      if (pos >= BLANK_CYC) begin
         o.an = ~(8'(1) << slot);
         if (lamp) begin
            o.seg = 7'h00;
            o.dp  = 1'b0;
         end else if (c[6]) begin
            o.seg = 7'h7F;
            o.dp  = 1'b1;
         end else begin
            o.seg = seg_tab[c[3:0]];
            o.dp  = ~c[5];
         end
      end
      return o;
   endfunction

   task automatic drive_inputs();
      dif.d0 = d_nxt[0];
      dif.d1 = d_nxt[1];
      dif.d2 = d_nxt[2];
      dif.d3 = d_nxt[3];
      dif.d4 = d_nxt[4];
      dif.d5 = d_nxt[5];
      dif.d6 = d_nxt[6];
      dif.d7 = d_nxt[7];
      dif.lamp_test = lamp_nxt;
   endtask

   // Entered and left at edge+2: apply inputs, predict the next edge, advance the model.
   task automatic cycle();
      out_t e;
      drive_inputs();
      e = model_out(m, lamp_nxt);
      if (m % FRAME == FRAME - 1) begin
         sh = d_nxt;
      end
      m++;
      @(posedge clk);
      exp_q.push_back(e);
      #2;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Runs until the next scan cycle to be driven is (slot, pos) of a frame.
   task automatic run_until(int slot, int pos);
      do cycle(); while (m % FRAME != slot * DIV + pos);
   endtask

   task automatic rand_digits();
      for (int k = 0; k < 8; k++) d_nxt[k] = 7'($urandom);
   endtask

   task automatic check_reset(string name);
      checks++;
      if (dif.an_n !== 8'hFF || dif.segs_n !== 7'h7F || dif.dp_n !== 1'b1) begin
         errors++;
         $display("FAIL %s: got an_n=%h segs_n=%h dp_n=%b, want an_n=ff segs_n=7f dp_n=1",
                  name, dif.an_n, dif.segs_n, dif.dp_n);
      end
   endtask

   task automatic do_reset(int hold);
      rst = 1'b0;
      exp_q.delete();
      #1;
      check_reset("reset_async");
      repeat (hold) @(posedge clk);
      #2;
      check_reset("reset_hold");
      rst = 1'b1;
      m   = 0;
      for (int k = 0; k < 8; k++) sh[k] = 7'h40;
   endtask

   // Monitor: scoreboard pop, single-anode rule and frame period.
   int         ncyc     = 0;
   int         last_fe  = -1;
   logic [7:0] prev_an  = 8'hFF;
   initial begin
      out_t       e;
      logic [7:0] on;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dif.an_n !== e.an || dif.segs_n !== e.seg || dif.dp_n !== e.dp) begin
               errors++;
               $display("FAIL scan_out cyc=%0d: got an_n=%h segs_n=%h dp_n=%b, want an_n=%h segs_n=%h dp_n=%b",
                        e.tag, dif.an_n, dif.segs_n, dif.dp_n, e.an, e.seg, e.dp);
            end
         end
         on = ~dif.an_n;
         if (rst) begin
            checks++;
            if ((on & (on - 8'd1)) != 8'd0) begin
               errors++;
               $display("FAIL one_anode: got an_n=%h, want at most one low bit", dif.an_n);
            end
         end
         if (!rst) begin
            last_fe = -1;
         end else if (dif.an_n === 8'hFE && prev_an === 8'hFF) begin
            if (last_fe >= 0) begin
               checks++;
               if (ncyc - last_fe != FRAME) begin
                  errors++;
                  $display("FAIL frame_period: got %0d cycles, want %0d", ncyc - last_fe, FRAME);
               end
            end
            last_fe = ncyc;
         end
         prev_an = dif.an_n;
         ncyc++;
      end
   end

   initial begin
      rand_digits();
      drive_inputs();
      @(posedge clk);
      #2;
      do_reset(3);

      // Blank first frame with changing inputs, then an asynchronous reset mid-slot.
      for (int i = 0; i < 45; i++) begin
         rand_digits();
         cycle();
      end
      do_reset(2);
      rand_digits();
      run_until(0, 0);

      // Steady codes with directed decode cases, shown for a full frame.
      rand_digits();
      d_nxt[3] = 7'h0B;
      d_nxt[5] = 7'h25;
      d_nxt[7] = 7'h61;
      run_until(0, 0);
      run(FRAME);

      // Tear-free update of d2.
      d_nxt[2] = 7'h01;
      run_until(0, 0);
      run_until(4, 3);
      d_nxt[2] = 7'h08;
      run_until(0, 0);
      run_until(1, 3);
      d_nxt[2] = 7'h03;
      run_until(0, 0);

      // Lamp test over a blank digit, spanning into the next slot's dark cycles.
      d_nxt[6] = 7'h40;
      run_until(0, 0);
      run_until(6, 4);
      lamp_nxt = 1'b1;
      run(6);
      lamp_nxt = 1'b0;
      run(20);

      // Three random frames with occasional lamp test and mid-frame input churn.
      for (int i = 0; i < 3 * FRAME; i++) begin
         if ($urandom_range(0, 7) == 0) rand_digits();
         lamp_nxt = ($urandom_range(0, 9) == 0);
         cycle();
      end
      lamp_nxt = 1'b0;
      run(4);

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
